permutation_prio_stage: RTL and testbench
=========================================

// Module: permutation_prio_stage
// PURPOSE
// - Pipeline stage directly upstream of one 2x2 permutation_steering node in the MinBD router.
// - Registers two incoming flit headers and derives from them the steering node's inputs:
//   ppv_0/1, vld_0/1 and winner.
// - PPV is computed by XY routing.
// - Winner is picked by golden > silver > round-robin priority.
// - A golden-epoch counter decides which packet source is golden.
// PARAMETERS
// - COORD_W    3   width of each X/Y coordinate
// - ID_W       4   width of source ID; golden_id wraps at 2**ID_W
// - EPOCH_LEN  64  cycles per golden epoch (>=2)
// PORTS
// - clk            in   1        rising-edge clock
// - reset          in   1        synchronous, active-high reset
// - local_x        in   COORD_W  this router's X (quasi-static)
// - local_y        in   COORD_W  this router's Y (quasi-static)
// - in_vld_0/1     in   1        flit present on input 0/1
// - in_dst_x_0/1   in   COORD_W  destination X
// - in_dst_y_0/1   in   COORD_W  destination Y
// - in_src_0/1     in   ID_W     source ID of packet
// - in_silver_0/1  in   1        silver-flit mark
// - out_vld_0/1    out  1        registered valid -> steering vld_0/1
// - out_ppv_0/1    out  4        productive port vector -> steering ppv_0/1
// - out_local_0/1  out  1        flit destined to this router (ppv==0)
// - out_winner     out  1        0: input 0 has priority, 1: input 1 -> steering winner
// - golden_id      out  ID_W     current golden source ID
// BEHAVIOUR
// - Reset values: all outputs 0, golden_id=0, epoch count=0, rr pointer=0.
// - Latency: exactly 1 cycle. Inputs sampled at edge N appear at outputs after edge N.
// - No backpressure: the deflection network never stalls, so a new pair is accepted every cycle.
// - PPV bits: [0]=N (dst_y>local_y), [1]=E (dst_x>local_x), [2]=S (dst_y<local_y),
//   [3]=W (dst_x<local_x). Comparisons are unsigned.
// - Two bits may be set at once (diagonal destination).
// - local: dst_x==local_x && dst_y==local_y -> ppv=4'b0000, out_local=1.
// - Invalid input: out_ppv=0 and out_local=0; out_vld mirrors in_vld.
// - Golden: flit is golden when in_vld && in_src==golden_id.
// - Winner, in order:
//   1. Exactly one valid -> that input.
//   2. Exactly one golden -> that input.
//   3. Exactly one silver -> that input.
//   4. Else -> rr pointer value.
// - Rule 4 also applies when neither input is valid; out_winner is then don't-care but still
//   equals rr.
// - Round-robin: rr toggles only on cycles where both inputs are valid and rule 4 decided the
//   winner.
// - Epoch counter: counts 0..EPOCH_LEN-1.
//   - On the cycle it is at EPOCH_LEN-1, it returns to 0 and golden_id increments.
//   - golden_id wraps 2**ID_W-1 -> 0.
//   - Golden classification uses golden_id before that cycle's update.
// - Reset mid-operation: next edge forces all state and outputs to reset values. The in-flight
//   pair is discarded (out_vld=0).
// CONFIGURATION
// - Macro PERM_GOLDEN_PRIO_EN.
// - Defined: golden epoch counter, golden_id port and winner rule 2 are present.
// - Undefined:
//   - Counter logic is removed.
//   - golden_id is tied to 0.
//   - Rule 2 is skipped; priority is valid > silver > rr.
//   - All other behaviour is identical.
// TESTING
// - Reset: hold reset 3 cycles with random inputs -> all outputs 0, golden_id=0.
// - PPV: local=(2,2); in0 dst=(4,1), in1 dst=(2,2), both valid -> next cycle:
//   out_ppv_0=4'b0110, out_ppv_1=0, out_local_1=1.
// - Golden: golden_id=0; in0 src=5 silver=1, in1 src=0 -> out_winner=1.
//   Swap srcs -> out_winner=0.
// - Round-robin: 4 cycles of both-valid, equal non-golden non-silver flits ->
//   out_winner 0,1,0,1; rr is unchanged by single-valid cycles inserted between them.
// - Epoch wrap: ID_W=2, EPOCH_LEN=4, run 16 cycles -> golden_id 0,1,2,3 each held 4 cycles,
//   then 0.
// - Build with PERM_GOLDEN_PRIO_EN undefined, rerun the golden test -> the silver flit wins;
//   golden_id stays 0.

Source files
------------

// File: rtl/permutation_prio_stage.sv
// permutation_prio_stage: one-cycle register stage in front of a MinBD 2x2
// permutation_steering node. Computes XY productive-port vectors, valid and
// local flags, and the winner bit (valid > golden > silver > round-robin).
// Optional feature macro: PERM_GOLDEN_PRIO_EN enables the golden-epoch
// counter, a live golden_id output and the golden priority rule. Without it,
// golden_id is tied to 0 and priority is valid > silver > round-robin.
module permutation_prio_stage #(
    parameter int unsigned COORD_W   = 3,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned EPOCH_LEN = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] local_x,
    input  logic [COORD_W-1:0] local_y,
    input  logic               in_vld_0,
    input  logic               in_vld_1,
    input  logic [COORD_W-1:0] in_dst_x_0,
    input  logic [COORD_W-1:0] in_dst_x_1,
    input  logic [COORD_W-1:0] in_dst_y_0,
    input  logic [COORD_W-1:0] in_dst_y_1,
    input  logic [ID_W-1:0]    in_src_0,
    input  logic [ID_W-1:0]    in_src_1,
    input  logic               in_silver_0,
    input  logic               in_silver_1,
    output logic               out_vld_0,
    output logic               out_vld_1,
    output logic [3:0]         out_ppv_0,
    output logic [3:0]         out_ppv_1,
    output logic               out_local_0,
    output logic               out_local_1,
    output logic               out_winner,
    output logic [ID_W-1:0]    golden_id
);

    localparam int unsigned EPOCH_W = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;

    // XY productive ports: [0]=N, [1]=E, [2]=S, [3]=W; zero for invalid or local flits
    function automatic logic [3:0] xy_ppv(
        input logic               vld,
        input logic [COORD_W-1:0] dx,
        input logic [COORD_W-1:0] dy,
        input logic [COORD_W-1:0] lx,
        input logic [COORD_W-1:0] ly
    );
        logic [3:0] p;
        p = '0;
        if (vld) begin
            p[0] = (dy > ly);
            p[1] = (dx > lx);
            p[2] = (dy < ly);
            p[3] = (dx < lx);
        end
        return p;
    endfunction

    logic [3:0]      ppv_0_d, ppv_1_d, ppv_0_q, ppv_1_q;
    logic            local_0_d, local_1_d, local_0_q, local_1_q;
    logic            vld_0_q, vld_1_q;
    logic            winner_d, winner_q;
    logic            rr_d, rr_q;
    logic            golden_0, golden_1;
    logic            silver_0, silver_1;
    logic [ID_W-1:0] gid_q;

`ifdef PERM_GOLDEN_PRIO_EN
    logic [EPOCH_W-1:0] epoch_q;

    // Epoch counter: wraps every EPOCH_LEN cycles and advances golden_id
    always_ff @(posedge clk) begin
        if (reset) begin
            epoch_q <= '0;
            gid_q   <= '0;
        end else if (epoch_q == EPOCH_W'(EPOCH_LEN - 1)) begin
            epoch_q <= '0;
            gid_q   <= gid_q + 1'b1;
        end else begin
            epoch_q <= epoch_q + 1'b1;
        end
    end

    assign golden_0 = in_vld_0 && (in_src_0 == gid_q);
    assign golden_1 = in_vld_1 && (in_src_1 == gid_q);
`else
    logic unused_src;

    assign gid_q      = '0;
    assign golden_0   = 1'b0;
    assign golden_1   = 1'b0;
    assign unused_src = ^{in_src_0, in_src_1, EPOCH_W[0]};
`endif

    assign silver_0 = in_vld_0 && in_silver_0;
    assign silver_1 = in_vld_1 && in_silver_1;

    // Next-state for port vectors, local flags, winner and round-robin pointer
    always_comb begin
        ppv_0_d   = xy_ppv(in_vld_0, in_dst_x_0, in_dst_y_0, local_x, local_y);
        ppv_1_d   = xy_ppv(in_vld_1, in_dst_x_1, in_dst_y_1, local_x, local_y);
        local_0_d = in_vld_0 && (in_dst_x_0 == local_x) && (in_dst_y_0 == local_y);
        local_1_d = in_vld_1 && (in_dst_x_1 == local_x) && (in_dst_y_1 == local_y);
        winner_d  = rr_q;
        rr_d      = rr_q;
        if (in_vld_0 ^ in_vld_1) begin
            winner_d = in_vld_1;
        end
`ifdef PERM_GOLDEN_PRIO_EN
        else if (golden_0 ^ golden_1) begin
            winner_d = golden_1;
        end
`endif
        else if (silver_0 ^ silver_1) begin
            winner_d = silver_1;
        end else if (in_vld_0 && in_vld_1) begin
            // Pointer only advances when it actually arbitrated a real contention
            rr_d = ~rr_q;
        end
    end

    // Output registers and round-robin pointer; reset discards the in-flight pair
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_0_q   <= 1'b0;
            vld_1_q   <= 1'b0;
            ppv_0_q   <= '0;
            ppv_1_q   <= '0;
            local_0_q <= 1'b0;
            local_1_q <= 1'b0;
            winner_q  <= 1'b0;
            rr_q      <= 1'b0;
        end else begin
            vld_0_q   <= in_vld_0;
            vld_1_q   <= in_vld_1;
            ppv_0_q   <= ppv_0_d;
            ppv_1_q   <= ppv_1_d;
            local_0_q <= local_0_d;
            local_1_q <= local_1_d;
            winner_q  <= winner_d;
            rr_q      <= rr_d;
        end
    end

    assign out_vld_0   = vld_0_q;
    assign out_vld_1   = vld_1_q;
    assign out_ppv_0   = ppv_0_q;
    assign out_ppv_1   = ppv_1_q;
    assign out_local_0 = local_0_q;
    assign out_local_1 = local_1_q;
    assign out_winner  = winner_q;
    assign golden_id   = gid_q;

endmodule

// File: tb/tb_permutation_prio_stage.sv
// Directed bench for permutation_prio_stage (COORD_W=3, ID_W=2, EPOCH_LEN=4).
// Expectations follow the PERM_GOLDEN_PRIO_EN setting of the build.
module tb_permutation_prio_stage;

`ifdef PERM_GOLDEN_PRIO_EN
    localparam bit GOLD_EN = 1'b1;
`else
    localparam bit GOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] local_x, local_y;
    logic       in_vld_0, in_vld_1;
    logic [2:0] in_dst_x_0, in_dst_x_1, in_dst_y_0, in_dst_y_1;
    logic [1:0] in_src_0, in_src_1;
    logic       in_silver_0, in_silver_1;
    logic       out_vld_0, out_vld_1;
    logic [3:0] out_ppv_0, out_ppv_1;
    logic       out_local_0, out_local_1;
    logic       out_winner;
    logic [1:0] golden_id;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    permutation_prio_stage #(
        .COORD_W  (3),
        .ID_W     (2),
        .EPOCH_LEN(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .local_x    (local_x),
        .local_y    (local_y),
        .in_vld_0   (in_vld_0),
        .in_vld_1   (in_vld_1),
        .in_dst_x_0 (in_dst_x_0),
        .in_dst_x_1 (in_dst_x_1),
        .in_dst_y_0 (in_dst_y_0),
        .in_dst_y_1 (in_dst_y_1),
        .in_src_0   (in_src_0),
        .in_src_1   (in_src_1),
        .in_silver_0(in_silver_0),
        .in_silver_1(in_silver_1),
        .out_vld_0  (out_vld_0),
        .out_vld_1  (out_vld_1),
        .out_ppv_0  (out_ppv_0),
        .out_ppv_1  (out_ppv_1),
        .out_local_0(out_local_0),
        .out_local_1(out_local_1),
        .out_winner (out_winner),
        .golden_id  (golden_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(
        input logic v0, input logic [2:0] x0, input logic [2:0] y0, input logic [1:0] s0, input logic sv0,
        input logic v1, input logic [2:0] x1, input logic [2:0] y1, input logic [1:0] s1, input logic sv1
    );
        in_vld_0 = v0; in_dst_x_0 = x0; in_dst_y_0 = y0; in_src_0 = s0; in_silver_0 = sv0;
        in_vld_1 = v1; in_dst_x_1 = x1; in_dst_y_1 = y1; in_src_1 = s1; in_silver_1 = sv1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for three edges with random inputs; every output must read zero
    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 1'($urandom));
            tick();
            check("reset_outs",
                  {out_vld_0, out_vld_1, out_ppv_0, out_ppv_1, out_local_0, out_local_1, out_winner, golden_id},
                  32'h0);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        local_x = 3'd2;
        local_y = 3'd2;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // PPV / local / invalid handling
        do_reset();
        drive(1, 4, 1, 3, 0, 1, 2, 2, 3, 0);
        tick();
        check("ppv0_se", out_ppv_0, 4'b0110);
        check("ppv1_local", out_ppv_1, 4'b0000);
        check("local1", out_local_1, 1'b1);
        check("local0", out_local_0, 1'b0);
        check("vld_both", {out_vld_0, out_vld_1}, 2'b11);
        check("win_rr_first", out_winner, 1'b0);
        drive(1, 0, 5, 3, 0, 0, 4, 4, 3, 0);
        tick();
        check("ppv0_nw", out_ppv_0, 4'b1001);
        check("ppv1_invalid", out_ppv_1, 4'b0000);
        check("vld1_low", out_vld_1, 1'b0);
        check("win_only0", out_winner, 1'b0);
        drive(0, 2, 2, 3, 0, 1, 5, 5, 3, 0);
        tick();
        check("local0_invalid", out_local_0, 1'b0);
        check("ppv0_invalid", out_ppv_0, 4'b0000);
        check("ppv1_ne", out_ppv_1, 4'b0011);
        check("win_only1", out_winner, 1'b1);

        // Golden vs silver priority
        do_reset();
        drive(1, 4, 4, 1, 1, 1, 4, 4, 0, 0);
        tick();
        check("gold_in1", out_winner, GOLD_EN ? 1'b1 : 1'b0);
        check("gid_e1", golden_id, 2'd0);
        drive(1, 4, 4, 0, 1, 1, 4, 4, 1, 0);
        tick();
        check("gold_in0", out_winner, 1'b0);
        drive(1, 4, 4, 2, 0, 1, 4, 4, 2, 1);
        tick();
        check("silver_in1", out_winner, 1'b1);
        check("gid_e3", golden_id, 2'd0);
        drive(1, 4, 4, 2, 0, 1, 4, 4, 2, 0);
        tick();
        check("rr_untouched", out_winner, 1'b0);
        check("gid_e4", golden_id, GOLD_EN ? 2'd1 : 2'd0);

        // Round-robin with single-valid and idle cycles interleaved
        do_reset();
        drive(1, 5, 5, 3, 0, 1, 5, 5, 3, 0); tick(); check("rr_a", out_winner, 1'b0);
        drive(1, 5, 5, 3, 0, 0, 5, 5, 3, 0); tick(); check("rr_single0", out_winner, 1'b0);
        drive(1, 5, 5, 3, 0, 1, 5, 5, 3, 0); tick(); check("rr_b", out_winner, 1'b1);
        drive(0, 5, 5, 3, 0, 1, 5, 5, 3, 0); tick(); check("rr_single1", out_winner, 1'b1);
        drive(1, 5, 5, 3, 0, 1, 5, 5, 3, 0); tick(); check("rr_c", out_winner, 1'b0);
        drive(1, 5, 5, 3, 0, 1, 5, 5, 3, 0); tick(); check("rr_d", out_winner, 1'b1);
        drive(0, 5, 5, 3, 1, 0, 5, 5, 3, 0); tick();
        check("idle_win_rr", out_winner, 1'b0);
        check("idle_outs", {out_vld_0, out_vld_1, out_ppv_0, out_ppv_1, out_local_0, out_local_1}, 32'h0);
        drive(1, 5, 5, 3, 0, 1, 5, 5, 3, 0); tick(); check("rr_e", out_winner, 1'b0);

        // Reset mid-stream discards in-flight pair and clears rr (now 1)
        reset = 1'b1;
        drive(1, 1, 1, 3, 0, 1, 1, 1, 3, 0);
        tick();
        check("midreset_outs",
              {out_vld_0, out_vld_1, out_ppv_0, out_ppv_1, out_local_0, out_local_1, out_winner, golden_id},
              32'h0);
        reset = 1'b0;
        tick();
        check("rr_after_reset", out_winner, 1'b0);
        check("vld_after_reset", {out_vld_0, out_vld_1}, 2'b11);

        // Epoch wrap: golden_id 0,1,2,3 each held 4 cycles, then 0
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("epoch_k0", golden_id, 2'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("epoch_k%0d", k), golden_id, GOLD_EN ? 2'((k / 4) % 4) : 2'd0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
